four_bit_adder: RTL and testbench

//   Registered 4-bit ripple-carry adder with carry-in: sum = a + b + cin.
//   The 5-bit result carries the carry-out in its MSB.

---
 rtl/four_bit_adder_full_adder.sv | 11 +
 rtl/four_bit_adder.sv | 20 ++
 tb/tb_four_bit_adder.sv | 77 +++++++
 3 files changed

// File: rtl/four_bit_adder_full_adder.sv
// full_adder: one-bit full adder cell for the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/four_bit_adder.sv
// four_bit_adder: registered ripple-carry adder, sum = a + b + cin with carry-out in the MSB
module four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  always_ff @(posedge clk)
    sum <= rst ? '0 : {c[WIDTH], s};
endmodule

// File: tb/tb_four_bit_adder.sv
// tb_four_bit_adder: scoreboard bench for the registered 4-bit adder
module tb_four_bit_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic [4:0] sum;
  logic [4:0] sb[$];
  int         nvec = 0;
  int         nerr = 0;

  four_bit_adder dut (.clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sum(sum));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] x,
                      input logic [3:0] y, input logic ci, input logic [4:0] exp);
    logic [4:0] e;
    @(negedge clk);
    rst = r; a = x; b = y; cin = ci;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(tag, sum, e);
  endtask

  function automatic logic [4:0] model(input logic r, input logic [3:0] x,
                                       input logic [3:0] y, input logic ci);
    return r ? 5'd0 : 5'(x) + 5'(y) + 5'(ci);
  endfunction

  initial begin
    step("rst0", 1'b1, 4'd9, 4'd9, 1'b1, 5'd0);
    step("rst1", 1'b1, 4'd9, 4'd9, 1'b1, 5'd0);
    step("post_rst", 1'b0, 4'd9, 4'd9, 1'b1, 5'd19);
    step("zero", 1'b0, 4'd0, 4'd0, 1'b0, 5'd0);
    step("10+2+1", 1'b0, 4'd10, 4'd2, 1'b1, 5'd13);
    step("8+3+1", 1'b0, 4'd8, 4'd3, 1'b1, 5'd12);
    step("6+7+0", 1'b0, 4'd6, 4'd7, 1'b0, 5'd13);
    step("max", 1'b0, 4'd15, 4'd15, 1'b1, 5'd31);
    step("15+0+1", 1'b0, 4'd15, 4'd0, 1'b1, 5'd16);
    // operands wiggled between edges must not disturb the registered result
    a = 4'd1; b = 4'd1; cin = 1'b0;
    #2;
    chk("hold", sum, 5'd16);
    for (int i = 0; i < 32; i++) begin
      logic [3:0] x, y;
      logic ci;
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      ci = 1'($urandom_range(0, 1));
      step("b2b", 1'b0, x, y, ci, model(1'b0, x, y, ci));
    end
    for (int i = 0; i < 512; i++) begin
      logic [3:0] x, y;
      logic ci;
      x = 4'(i >> 5);
      y = 4'(i >> 1);
      ci = 1'(i);
      if (i == 200) step("mid_rst", 1'b1, x, y, ci, 5'd0);
      step("sweep", 1'b0, x, y, ci, model(1'b0, x, y, ci));
    end
    chk("sb_empty", 5'(sb.size()), 5'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
